pc_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 32 +++
 rtl/redirect_latch.sv | 31 +++
 rtl/pc_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pc_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the PC sequencing front end (pc_ctrl).
package pipe_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Numerically larger source means higher redirect priority.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    BR   = 2'd1,
    MRET = 2'd2,
    TRAP = 2'd3
  } redir_src_t;

  function automatic redir_src_t pick_source(input logic trap,
                                             input logic mret,
                                             input logic br);
    redir_src_t src;
    src = NONE;
    if (trap)      src = TRAP;
    else if (mret) src = MRET;
    else if (br)   src = BR;
    return src;
  endfunction

endpackage

// File: rtl/redirect_latch.sv
// Holds one pending redirect (target + source) while a memory stall is in progress.
module redirect_latch #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [1:0]   src_in,
  input  logic [W-1:0] target_in,
  output logic [1:0]   src,
  output logic [W-1:0] target
);
  import pipe_pkg::*;

  logic take_new;

  // An equal-priority request replaces the held one, so the newest wins ties.
  assign take_new = load && (src_in != 2'(NONE)) && (src_in >= src);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      src    <= 2'(NONE);
      target <= '0;
    end else if (take_new) begin
      src    <= src_in;
      target <= target_in;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC selection, pause/flush sequencing and stall-time redirect holding.
// Optional stall watchdog enabled by defining STALL_WATCHDOG_EN.
module pc_ctrl #(
  parameter int unsigned     XLEN         = pipe_pkg::XLEN,
  parameter int unsigned     INST_BYTES   = pipe_pkg::INST_BYTES,
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int unsigned     WDOG_LIMIT   = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipeline_en,
  input  logic [XLEN-1:0] pc_cur,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret_req,
  input  logic [XLEN-1:0] epc,
  input  logic            hazard_stall,
  input  logic            mem_busy,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_pause,
  output logic            pc_flush,
  output logic            redirect_pending
`ifdef STALL_WATCHDOG_EN
  ,
  output logic            stall_timeout
`endif
);
  import pipe_pkg::*;

  localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || WDOG_LIMIT < 1 || WDOG_LIMIT > 65535)
  begin : g_param_check
    $error("pc_ctrl: FLUSH_CYCLES or WDOG_LIMIT out of range");
  end

  state_t          state, nxt_state;
  logic [3:0]      cnt, nxt_cnt;
  logic [1:0]      lat_src;
  logic [XLEN-1:0] lat_target;
  redir_src_t      new_src;
  logic [XLEN-1:0] new_target;
  logic [XLEN-1:0] seq_pc;
  logic            new_wins;
  logic            latch_load;
  logic            latch_clear;
  logic            take;
  logic            wd_fire;

  assign seq_pc = pc_cur + XLEN'(INST_BYTES);

  always_comb begin
    new_src = pipeline_en ? pick_source(trap_req | wd_fire, mret_req, br_taken) : NONE;
    case (new_src)
      TRAP:    new_target = trap_vec;
      MRET:    new_target = epc;
      BR:      new_target = br_target;
      default: new_target = pc_cur;
    endcase
    new_wins = (new_src != NONE) && (2'(new_src) >= lat_src);
  end

  always_comb begin
    pc_next          = seq_pc;
    pc_pause         = 1'b0;
    pc_flush         = 1'b0;
    redirect_pending = 1'b0;
    latch_load       = 1'b0;
    latch_clear      = 1'b0;
    take             = 1'b0;
    nxt_state        = state;
    nxt_cnt          = cnt;
    case (state)
      RUN: begin
        if (new_src != NONE && (!mem_busy || wd_fire)) begin
          pc_next  = new_target;
          pc_flush = 1'b1;
          take     = 1'b1;
        end else if (new_src != NONE) begin
          pc_pause   = 1'b1;
          pc_next    = pc_cur;
          latch_load = 1'b1;
          nxt_state  = HOLD;
        end else if (mem_busy || hazard_stall) begin
          pc_pause = 1'b1;
          pc_next  = pc_cur;
        end
      end
      HOLD: begin
        redirect_pending = 1'b1;
        // A request arriving on the release cycle still competes with the held one.
        if (wd_fire || (pipeline_en && !mem_busy)) begin
          pc_next     = new_wins ? new_target : lat_target;
          pc_flush    = 1'b1;
          latch_clear = 1'b1;
          take        = 1'b1;
        end else begin
          pc_pause   = 1'b1;
          pc_next    = pc_cur;
          latch_load = (new_src != NONE);
        end
      end
      FLUSH: begin
        pc_flush = 1'b1;
        pc_pause = mem_busy;
        if (new_src != NONE) begin
          pc_next = new_target;
          take    = 1'b1;
        end else begin
          nxt_cnt = cnt - 4'd1;
          if (cnt <= 4'd1) nxt_state = RUN;
        end
      end
      default: nxt_state = RUN;
    endcase

    if (take) begin
      nxt_cnt = RELOAD;
      if (FLUSH_CYCLES > 1) nxt_state = FLUSH;
      else                  nxt_state = RUN;
    end

    if (rst) begin
      pc_next          = RESET_PC;
      pc_pause         = 1'b0;
      pc_flush         = 1'b0;
      redirect_pending = 1'b0;
      latch_load       = 1'b0;
      latch_clear      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (pipeline_en) begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  redirect_latch #(
    .W (XLEN)
  ) u_latch (
    .clk       (clk),
    .rst       (rst),
    .clear     (latch_clear),
    .load      (latch_load),
    .src_in    (2'(new_src)),
    .target_in (new_target),
    .src       (lat_src),
    .target    (lat_target)
  );

`ifdef STALL_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        wd_flag;

  assign wd_fire       = pipeline_en && !rst && (wd_cnt >= 16'(WDOG_LIMIT));
  assign stall_timeout = wd_flag || wd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      wd_flag <= 1'b0;
    end else if (pipeline_en) begin
      if (wd_fire) begin
        wd_cnt  <= '0;
        wd_flag <= 1'b1;
      end else if (pc_pause && !pc_flush) begin
        wd_cnt <= wd_cnt + 16'd1;
      end else if (!pc_pause) begin
        wd_cnt <= '0;
      end
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed scenarios then randomized traffic vs. a reference model.
module tb_pc_ctrl;

  localparam int unsigned FC = 2;
`ifdef STALL_WATCHDOG_EN
  localparam int unsigned WDOG = 8;
`else
  localparam int unsigned WDOG = 1024;
`endif
  localparam logic [63:0] RPC = 64'h0;

  logic        clk;
  logic        rst, pipeline_en, br_taken, trap_req, mret_req, hazard_stall, mem_busy;
  logic [63:0] pc_cur, br_target, trap_vec, epc;
  logic [63:0] pc_next;
  logic        pc_pause, pc_flush, redirect_pending;
  logic        stall_timeout;

  pc_ctrl #(
    .XLEN         (64),
    .INST_BYTES   (4),
    .FLUSH_CYCLES (FC),
    .RESET_PC     (RPC),
    .WDOG_LIMIT   (WDOG)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pipeline_en      (pipeline_en),
    .pc_cur           (pc_cur),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .trap_req         (trap_req),
    .trap_vec         (trap_vec),
    .mret_req         (mret_req),
    .epc              (epc),
    .hazard_stall     (hazard_stall),
    .mem_busy         (mem_busy),
    .pc_next          (pc_next),
    .pc_pause         (pc_pause),
    .pc_flush         (pc_flush),
    .redirect_pending (redirect_pending)
`ifdef STALL_WATCHDOG_EN
    ,
    .stall_timeout    (stall_timeout)
`endif
  );
`ifndef STALL_WATCHDOG_EN
  assign stall_timeout = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc_next;
    logic        pause;
    logic        flush;
    logic        pend;
    logic        stall;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: remaining flush bubbles, optional pending redirect, stall counter.
  int          bubbles  = 0;
  bit          pend_v   = 0;
  int          pend_p   = 0;
  logic [63:0] pend_a   = '0;
  int          wd_cnt   = 0;
  bit          wd_flag  = 0;
  logic [63:0] pc_model = RPC;
  int          mem_left = 0;

  task automatic model_eval();
    exp_t        e;
    int          req_p;
    logic [63:0] req_a;
    bit          fire;
    e.pc_next = pc_cur + 64'd4;
    e.pause   = 0;
    e.flush   = 0;
    e.pend    = 0;
    fire  = !rst && pipeline_en && (wd_cnt >= int'(WDOG));
    req_p = 0;
    if (pipeline_en) req_p = (trap_req || fire) ? 3 : mret_req ? 2 : br_taken ? 1 : 0;
    req_a = (req_p == 3) ? trap_vec : (req_p == 2) ? epc : br_target;
`ifdef STALL_WATCHDOG_EN
    e.stall = wd_flag || fire;
`else
    e.stall = 0;
`endif
    if (rst) begin
      e.pc_next = RPC;
      bubbles = 0;
      pend_v  = 0;
    end else if (bubbles > 0) begin
      e.flush = 1;
      e.pause = mem_busy;
      if (req_p > 0) begin
        e.pc_next = req_a;
        bubbles = FC - 1;
      end else if (pipeline_en) begin
        bubbles--;
      end
    end else if (pend_v) begin
      e.pend = 1;
      if (fire || (pipeline_en && !mem_busy)) begin
        e.flush   = 1;
        e.pc_next = (req_p > 0 && req_p >= pend_p) ? req_a : pend_a;
        pend_v  = 0;
        bubbles = FC - 1;
      end else begin
        e.pause   = 1;
        e.pc_next = pc_cur;
        if (req_p > 0 && req_p >= pend_p) begin
          pend_p = req_p;
          pend_a = req_a;
        end
      end
    end else if (req_p > 0 && (!mem_busy || fire)) begin
      e.pc_next = req_a;
      e.flush   = 1;
      bubbles   = FC - 1;
    end else if (req_p > 0) begin
      e.pause   = 1;
      e.pc_next = pc_cur;
      pend_v = 1;
      pend_p = req_p;
      pend_a = req_a;
    end else if (mem_busy || hazard_stall) begin
      e.pause   = 1;
      e.pc_next = pc_cur;
    end
    if (rst) begin
      wd_cnt  = 0;
      wd_flag = 0;
    end else if (pipeline_en) begin
      if (fire) begin
        wd_cnt  = 0;
        wd_flag = 1;
      end else if (e.pause && !e.flush) wd_cnt++;
      else if (!e.pause) wd_cnt = 0;
    end
    if (rst) pc_model = RPC;
    else if (pipeline_en && (e.flush || !e.pause)) pc_model = e.pc_next;
    sb.push_back(e);
  endtask

  // Inputs for the current cycle are already applied; record expectation and advance.
  task automatic cycle();
    model_eval();
    @(posedge clk);
    #2;
    pc_cur = pc_model;
  endtask

  task automatic idle();
    rst = 0; pipeline_en = 1; br_taken = 0; trap_req = 0; mret_req = 0;
    hazard_stall = 0; mem_busy = 0;
  endtask

  task automatic set_pc(input logic [63:0] v);
    pc_cur   = v;
    pc_model = v;
  endtask

  task automatic rand_inputs();
    rst          = ($urandom_range(99) < 2);
    pipeline_en  = ($urandom_range(99) < 85);
    br_taken     = ($urandom_range(99) < 15);
    trap_req     = ($urandom_range(99) < 5);
    mret_req     = ($urandom_range(99) < 6);
    hazard_stall = ($urandom_range(99) < 10);
    if (mem_left > 0) begin
      mem_busy = 1; mem_left--;
    end else if ($urandom_range(99) < 12) begin
      mem_busy = 1; mem_left = $urandom_range(6);
    end else begin
      mem_busy = 0;
    end
    br_target = {$urandom(), $urandom()} & ~64'h3;
    trap_vec  = {$urandom(), $urandom()} & ~64'h3;
    epc       = {$urandom(), $urandom()} & ~64'h3;
    if ($urandom_range(99) < 4) set_pc({$urandom(), $urandom()} & ~64'h3);
    else if ($urandom_range(99) < 2) set_pc(64'hFFFF_FFFF_FFFF_FFFC);
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one DUT response per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check64("pc_next", pc_next, e.pc_next);
        check64("pc_pause", 64'(pc_pause), 64'(e.pause));
        check64("pc_flush", 64'(pc_flush), 64'(e.flush));
        check64("redirect_pending", 64'(redirect_pending), 64'(e.pend));
`ifdef STALL_WATCHDOG_EN
        check64("stall_timeout", 64'(stall_timeout), 64'(e.stall));
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    idle();
    rst = 1;
    br_target = 64'h1000; trap_vec = 64'h80; epc = 64'h500;
    set_pc(64'h0);
    @(posedge clk); #2;

    // Reset, then sequential fetch from 0x0
    cycle(); cycle();
    idle();
    repeat (3) cycle();

    // Taken branch: same-cycle redirect, then bubbles
    br_taken = 1; br_target = 64'h1000; cycle();
    idle(); repeat (3) cycle();

    // Redirects during a 5-cycle memory stall; trap must displace the branch
    mem_busy = 1; cycle();
    br_taken = 1; br_target = 64'h2000; cycle();
    br_taken = 0; cycle();
    trap_req = 1; trap_vec = 64'h80; cycle();
    trap_req = 0; cycle();
    mem_busy = 0; repeat (3) cycle();

    // Priority, then wrap of the sequential increment
    trap_req = 1; br_taken = 1; mret_req = 1; trap_vec = 64'h180; cycle();
    idle(); repeat (2) cycle();
    mret_req = 1; br_taken = 1; epc = 64'h700; cycle();
    idle(); repeat (2) cycle();
    set_pc(64'hFFFF_FFFF_FFFF_FFFC); cycle();

    // Enable low in the middle of a flush
    br_taken = 1; br_target = 64'h3000; cycle();
    idle(); pipeline_en = 0; br_taken = 1; repeat (3) cycle();
    idle(); repeat (3) cycle();

    // Reset while holding a redirect
    mem_busy = 1; br_taken = 1; br_target = 64'h4000; cycle();
    br_taken = 0; cycle();
    rst = 1; cycle();
    idle(); mem_busy = 1; cycle();
    mem_busy = 0; repeat (2) cycle();

`ifdef STALL_WATCHDOG_EN
    // Long stall trips the watchdog
    mem_busy = 1; trap_vec = 64'h900; repeat (12) cycle();
    idle(); repeat (3) cycle();
    rst = 1; cycle();
    idle(); cycle();
`endif

    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      cycle();
    end

    idle();
    @(negedge clk); #1;
    check64("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
